// File: rtl/rv32_mod_data_mem_responder_if.sv
// dext_* bus between the hart's load/store unit (master) and the data memory (slave).
interface rv32_mod_data_mem_responder_if;
   logic        dext_req;
   logic        dext_wr;
   logic [3:0]  dext_be;
   logic [31:0] dext_addr;
   logic [31:0] dext_do;
   logic        dext_ack;
   logic        dext_err;
   logic [31:0] dext_di;

   modport master (
      output dext_req, dext_wr, dext_be, dext_addr, dext_do,
      input  dext_ack, dext_err, dext_di
   );

   modport slave (
      input  dext_req, dext_wr, dext_be, dext_addr, dext_do,
      output dext_ack, dext_err, dext_di
   );
endinterface

// File: rtl/rv32_mod_data_mem_responder.sv
// Word-organised data memory answering the dext_* bus with one ack/err pulse per request.
// Optional RV32_DMEM_STALL_INJECT_EN adds 0..3 pseudo-random wait states per request.
module rv32_mod_data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_STATES = 0
) (
   input logic                         clk,
   input logic                         reset_n,
   rv32_mod_data_mem_responder_if.slave bus
);
   localparam int unsigned AW    = $clog2(DEPTH_WORDS);
   localparam int unsigned CNT_W = 5;
   localparam logic [CNT_W-1:0] WS_LOAD = CNT_W'(WAIT_STATES);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_load;

   logic             wr_q;
   logic             err_q;
   logic [3:0]       be_q;
   logic [AW-1:0]    idx_q;
   logic [31:0]      wdata_q;

   logic [31:0]      mem [DEPTH_WORDS];

   logic             in_idle;
   logic             in_err;
   logic             enter_resp;
   logic             cur_wr;
   logic             cur_err;
   logic [3:0]       cur_be;
   logic [AW-1:0]    cur_idx;
   logic [31:0]      cur_wdata;

`ifdef RV32_DMEM_STALL_INJECT_EN
   logic [7:0] lfsr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) lfsr <= 8'hA5;
      else          lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

   assign cnt_load = WS_LOAD + {3'b000, lfsr[1:0]};
`else
   assign cnt_load = WS_LOAD;
`endif

   // BASE_ADDR is aligned to the array size, so the window test is a tag compare.
   assign in_err = (bus.dext_addr[31:AW+2] != BASE_ADDR[31:AW+2]) ||
                   (bus.dext_addr[1:0] != 2'b00) ||
                   (bus.dext_be == 4'b0000);

   // With zero wait states the commit edge is the capture edge, so use the live bus then.
   assign in_idle   = (state == IDLE);
   assign cur_wr    = in_idle ? bus.dext_wr            : wr_q;
   assign cur_err   = in_idle ? in_err                 : err_q;
   assign cur_be    = in_idle ? bus.dext_be            : be_q;
   assign cur_idx   = in_idle ? bus.dext_addr[AW+1:2]  : idx_q;
   assign cur_wdata = in_idle ? bus.dext_do            : wdata_q;

   assign enter_resp = (in_idle && bus.dext_req && (cnt_load == '0)) ||
                       ((state == WAIT) && (cnt == CNT_W'(1)));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         cnt          <= '0;
         wr_q         <= 1'b0;
         err_q        <= 1'b0;
         be_q         <= '0;
         idx_q        <= '0;
         wdata_q      <= '0;
         bus.dext_ack <= 1'b0;
         bus.dext_err <= 1'b0;
         bus.dext_di  <= '0;
      end else begin
         bus.dext_ack <= enter_resp && !cur_err;
         bus.dext_err <= enter_resp && cur_err;
         bus.dext_di  <= (enter_resp && !cur_wr && !cur_err) ? mem[cur_idx] : '0;
         case (state)
            IDLE: begin
               if (bus.dext_req) begin
                  wr_q    <= bus.dext_wr;
                  err_q   <= in_err;
                  be_q    <= bus.dext_be;
                  idx_q   <= bus.dext_addr[AW+1:2];
                  wdata_q <= bus.dext_do;
                  cnt     <= cnt_load;
                  state   <= (cnt_load != '0) ? WAIT : RESP;
               end
            end
            WAIT: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) state <= RESP;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Array is not reset; reset_n gating keeps a request seen during reset from writing.
   always_ff @(posedge clk) begin
      if (reset_n && enter_resp && cur_wr && !cur_err) begin
         for (int b = 0; b < 4; b++) begin
            if (cur_be[b]) mem[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
         end
      end
   end
endmodule

// File: tb/tb_rv32_mod_data_mem_responder.sv
// Directed bench: vector table on a zero-wait instance, hand sequences for wait states and reset.
module tb_rv32_mod_data_mem_responder;
   logic clk = 1'b0;
   logic rst_n;
   logic rst4_n;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rv32_mod_data_mem_responder_if bus0 ();
   rv32_mod_data_mem_responder_if bus3 ();
   rv32_mod_data_mem_responder_if bus4 ();

   rv32_mod_data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_ws0 (
      .clk(clk), .reset_n(rst_n), .bus(bus0));
   rv32_mod_data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_ws3 (
      .clk(clk), .reset_n(rst_n), .bus(bus3));
   rv32_mod_data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(4)) u_ws4 (
      .clk(clk), .reset_n(rst4_n), .bus(bus4));

   typedef struct {
      logic        wr;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] data;
      logic        ack;
      logic        err;
      logic [31:0] di;
   } vec_t;

   vec_t vecs [18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Called just after a falling edge; capture happens on the next rising edge.
   task automatic txn0(input vec_t v, input int id);
      bus0.dext_req  = 1'b1;
      bus0.dext_wr   = v.wr;
      bus0.dext_be   = v.be;
      bus0.dext_addr = v.addr;
      bus0.dext_do   = v.data;
      @(negedge clk);
      check($sformatf("v%0d_ack", id), {31'b0, bus0.dext_ack}, {31'b0, v.ack});
      check($sformatf("v%0d_err", id), {31'b0, bus0.dext_err}, {31'b0, v.err});
      check($sformatf("v%0d_di", id), bus0.dext_di, v.di);
      bus0.dext_req = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_idle", id),
            {30'b0, bus0.dext_ack, bus0.dext_err} | bus0.dext_di, 32'h0);
   endtask

   initial begin
      bus0.dext_req = 0; bus0.dext_wr = 0; bus0.dext_be = 0; bus0.dext_addr = 0; bus0.dext_do = 0;
      bus3.dext_req = 0; bus3.dext_wr = 0; bus3.dext_be = 0; bus3.dext_addr = 0; bus3.dext_do = 0;
      bus4.dext_req = 0; bus4.dext_wr = 0; bus4.dext_be = 0; bus4.dext_addr = 0; bus4.dext_do = 0;
      rst_n  = 1'b0;
      rst4_n = 1'b0;

      vecs[0]  = '{1'b1, 4'hF, 32'h10,       32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
      vecs[1]  = '{1'b0, 4'hF, 32'h10,       32'h0,        1'b1, 1'b0, 32'hDEADBEEF};
      vecs[2]  = '{1'b1, 4'h2, 32'h10,       32'h00005A00, 1'b1, 1'b0, 32'h0};
      vecs[3]  = '{1'b0, 4'hF, 32'h10,       32'h0,        1'b1, 1'b0, 32'hDEAD5AEF};
      vecs[4]  = '{1'b0, 4'hF, 32'h1000,     32'h0,        1'b0, 1'b1, 32'h0};
      vecs[5]  = '{1'b1, 4'hF, 32'h11,       32'h11111111, 1'b0, 1'b1, 32'h0};
      vecs[6]  = '{1'b1, 4'h0, 32'h10,       32'hFFFFFFFF, 1'b0, 1'b1, 32'h0};
      vecs[7]  = '{1'b0, 4'hF, 32'h10,       32'h0,        1'b1, 1'b0, 32'hDEAD5AEF};
      vecs[8]  = '{1'b1, 4'hF, 32'h0,        32'h1,        1'b1, 1'b0, 32'h0};
      vecs[9]  = '{1'b1, 4'hF, 32'h4,        32'h2,        1'b1, 1'b0, 32'h0};
      vecs[10] = '{1'b1, 4'hF, 32'h8,        32'h3,        1'b1, 1'b0, 32'h0};
      vecs[11] = '{1'b1, 4'hF, 32'hFFC,      32'hA5A5A5A5, 1'b1, 1'b0, 32'h0};
      vecs[12] = '{1'b0, 4'hF, 32'hFFC,      32'h0,        1'b1, 1'b0, 32'hA5A5A5A5};
      vecs[13] = '{1'b0, 4'hF, 32'hFFFFFFFC, 32'h0,        1'b0, 1'b1, 32'h0};
      vecs[14] = '{1'b1, 4'hF, 32'h14,       32'h0,        1'b1, 1'b0, 32'h0};
      vecs[15] = '{1'b1, 4'h9, 32'h14,       32'h11223344, 1'b1, 1'b0, 32'h0};
      vecs[16] = '{1'b0, 4'hF, 32'h14,       32'h0,        1'b1, 1'b0, 32'h11000044};
      vecs[17] = '{1'b0, 4'hF, 32'h12,       32'h0,        1'b0, 1'b1, 32'h0};

      repeat (2) @(negedge clk);
      check("rst_ack", {31'b0, bus0.dext_ack}, 32'h0);
      check("rst_err", {31'b0, bus0.dext_err}, 32'h0);
      check("rst_di", bus0.dext_di, 32'h0);
      check("rst_ws3_ack", {31'b0, bus3.dext_ack}, 32'h0);
      check("rst_ws4_di", bus4.dext_di, 32'h0);
      rst_n  = 1'b1;
      rst4_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 18; i++) txn0(vecs[i], i);

      // Back-to-back reads with req held high: ack, gap, ack, gap, ack.
      bus0.dext_req  = 1'b1;
      bus0.dext_wr   = 1'b0;
      bus0.dext_be   = 4'hF;
      bus0.dext_addr = 32'h0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("b2b%0d_ack", i), {31'b0, bus0.dext_ack}, 32'h1);
         check($sformatf("b2b%0d_di", i), bus0.dext_di, 32'(i + 1));
         if (i == 2) bus0.dext_req = 1'b0;
         else        bus0.dext_addr = 32'(4 * (i + 1));
         @(negedge clk);
         check($sformatf("b2b%0d_gap", i), {31'b0, bus0.dext_ack}, 32'h0);
      end

      // Three wait states: write, then a read whose req drops right after capture.
      bus3.dext_req = 1'b1; bus3.dext_wr = 1'b1; bus3.dext_be = 4'hF;
      bus3.dext_addr = 32'h40; bus3.dext_do = 32'h0BADF00D;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         check($sformatf("ws3w_ack_c%0d", k), {31'b0, bus3.dext_ack}, {31'b0, k == 4});
         check($sformatf("ws3w_err_c%0d", k), {31'b0, bus3.dext_err}, 32'h0);
         if (k == 4) bus3.dext_req = 1'b0;
      end
      bus3.dext_req = 1'b1; bus3.dext_wr = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         check($sformatf("ws3r_ack_c%0d", k), {31'b0, bus3.dext_ack}, {31'b0, k == 4});
         check($sformatf("ws3r_di_c%0d", k), bus3.dext_di, (k == 4) ? 32'h0BADF00D : 32'h0);
         if (k == 1) begin
            bus3.dext_req  = 1'b0;
            bus3.dext_wr   = 1'b1;
            bus3.dext_addr = 32'h44;
         end
      end

      // Four wait states: preload, abort a write with reset, then read back.
      bus4.dext_req = 1'b1; bus4.dext_wr = 1'b1; bus4.dext_be = 4'hF;
      bus4.dext_addr = 32'h20; bus4.dext_do = 32'hCAFEF00D;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         check($sformatf("ws4pre_ack_c%0d", k), {31'b0, bus4.dext_ack}, {31'b0, k == 5});
         if (k == 5) bus4.dext_req = 1'b0;
      end
      bus4.dext_req = 1'b1; bus4.dext_do = 32'h12345678;
      repeat (2) @(negedge clk);
      rst4_n = 1'b0;
      bus4.dext_req = 1'b0;
      #1;
      check("rst_mid_out", {30'b0, bus4.dext_ack, bus4.dext_err} | bus4.dext_di, 32'h0);
      @(negedge clk);
      check("rst_mid_hold", {30'b0, bus4.dext_ack, bus4.dext_err} | bus4.dext_di, 32'h0);
      rst4_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         check($sformatf("abort_noresp_c%0d", k), {30'b0, bus4.dext_ack, bus4.dext_err}, 32'h0);
      end
      bus4.dext_req = 1'b1; bus4.dext_wr = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         check($sformatf("ws4rd_ack_c%0d", k), {31'b0, bus4.dext_ack}, {31'b0, k == 5});
         if (k == 5) begin
            check("ws4rd_di", bus4.dext_di, 32'hCAFEF00D);
            bus4.dext_req = 1'b0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
